// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchronizer, 3-sample majority voting,
// configurable data width, parity and stop bits, with a one-word output holding register.
module uart_rx_param #(
  parameter int unsigned CLK_FREQ  = 10000000,
  parameter int unsigned BAUD_RATE = 19200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned Half       = ClksPerBit / 2;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned BitW       = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] CntHalf  = CntW'(Half);
  localparam logic [CntW-1:0] CntLast  = CntW'(ClksPerBit - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(DATA_BITS - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);
  localparam logic            ParOdd   = (PARITY == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_sync_q;
  logic [2:0]             maj_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   pe_q, pe_d;
  logic                   fe_q, fe_d;
  logic                   ovr_q, ovr_d;
  logic                   maj, fall, tick, done;

  assign maj  = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);
  // maj_q[0] holds the previous synchronized sample, so this is a synchronized 1->0 edge.
  assign fall = maj_q[0] & ~rx_sync_q;
  assign tick = (cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d    = StStart;
          cnt_d      = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          state_d = maj ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (tick) begin
          cnt_d     = '0;
          shift_d   = {maj, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BitW'(1);
          if (bit_cnt_q == BitLast) state_d = (PARITY != 0) ? StParity : StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = StStop;
          if (maj != ((^shift_q) ^ ParOdd)) par_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (tick) begin
          cnt_d = '0;
          if (!maj) frm_err_d = 1'b1;
          if (stop_cnt_q == StopLast) begin
            state_d = StIdle;
            done    = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = 1'b0;
    if (done) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        pe_d    = par_err_d;
        fe_d    = frm_err_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      maj_q      <= 3'b111;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      maj_q      <= {maj_q[1:0], rx_sync_q};
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = pe_q;
  assign frame_err_o  = fe_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 10000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 19200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, payload width; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-006 SHALL have port clk_i, input, 1, system clock.
REQ-007 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port rx_i, input, 1, asynchronous serial line; idle high.
REQ-009 SHALL have port data_o, output, DATA_BITS, received payload, LSB = first bit on line.
REQ-010 SHALL have port valid_o, output, 1, data_o and error flags are valid.
REQ-011 SHALL have port ready_i, input, 1, consumer accepts the held word.
REQ-012 SHALL have port parity_err_o, output, 1, parity mismatch on the held word; 0 when PARITY=0.
REQ-013 SHALL have port frame_err_o, output, 1, a stop bit on the held word sampled 0.
REQ-014 SHALL have port overrun_o, output, 1, one-cycle pulse when a frame is dropped.
REQ-015 SHALL have port busy_o, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL compute CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division) and HALF = CLKS_PER_BIT/2, and size the baud counter as $clog2(CLKS_PER_BIT).
REQ-017 SHALL pass rx_i through a 2-flop synchronizer that resets to 1; all logic SHALL use the synchronized value only.
REQ-018 SHALL keep a 3-deep shift register of synchronized samples; every bit decision SHALL be the majority of these 3 samples at the sample cycle.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE -> START SHALL occur on a synchronized 1->0 transition, with the baud counter cleared to 0.
REQ-021 In START, at counter == HALF: majority 0 SHALL go to DATA with the counter cleared; majority 1 SHALL return to IDLE (glitch rejected, nothing delivered).
REQ-022 In DATA, PARITY and STOP, a sample SHALL be taken when counter == CLKS_PER_BIT-1, and the counter SHALL then clear; otherwise the counter SHALL increment.
REQ-023 DATA SHALL shift in DATA_BITS samples LSB first, using a bit counter of $clog2(DATA_BITS+1) bits, then go to PARITY if PARITY != 0, else to STOP.
REQ-024 PARITY SHALL take one sample and compare it with the XOR of the data bits (even) or its inverse (odd); a mismatch SHALL set the internal parity error.
REQ-025 STOP SHALL take STOP_BITS samples; any sample equal to 0 SHALL set the internal frame error.
REQ-026 After the last stop sample, the FSM SHALL return to IDLE in the same cycle so that a new start edge can be detected immediately.
REQ-027 On frame completion with valid_o == 0, data_o, parity_err_o and frame_err_o SHALL load, and valid_o SHALL assert, on the next clock edge.
REQ-028 valid_o SHALL stay high with data_o and the flags stable until a clock edge where ready_i == 1, then deassert.
REQ-029 On frame completion with valid_o == 1 and ready_i == 0, the new frame SHALL be discarded, the held word kept, and overrun_o pulsed high for exactly 1 cycle.
REQ-030 On frame completion with valid_o == 1 and ready_i == 1 in the same cycle, the new word SHALL load, valid_o SHALL stay high, and no overrun SHALL be signalled.
REQ-031 Frames with parity or frame errors SHALL still be delivered, with their flags set.

Reset
REQ-032 While reset_i is high, the block SHALL go to state IDLE, clear all counters, set the synchronizer and majority flops to 1, and drive data_o = 0, valid_o = 0, parity_err_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0.
REQ-033 A reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for a new 1->0 edge and SHALL NOT deliver the partial frame.

Verification (bench params CLK_FREQ=1600, BAUD_RATE=100 -> 16 clk/bit)
REQ-034 8N1, send 0xA5 with ready_i = 1 -> one valid_o pulse, data_o = 0xA5, parity_err_o = 0, frame_err_o = 0.
REQ-035 PARITY=1, send 0x07 with the parity bit forced to 0 -> data_o = 0x07, parity_err_o = 1; repeat with parity bit 1 -> parity_err_o = 0.
REQ-036 rx_i low for 4 clocks, then high -> busy_o goes high then returns to 0, and valid_o never asserts.
REQ-037 STOP_BITS=2, send 0x3C with the second stop bit 0 -> data_o = 0x3C, frame_err_o = 1.
REQ-038 ready_i = 0, send 0x11 then 0x22 -> data_o stays 0x11, overrun_o pulses 1 cycle after the second frame; raising ready_i then drops valid_o.
REQ-039 Assert reset_i during data bit 3 of 0x55, release, then send 0x99 -> only 0x99 is delivered.
